// File: rtl/pwp_pkg.sv
// Shared definitions for the main_ram block.
//   state_e  : access FSM encoding (IDLE=0, WAIT=1, DONE=2)
//   RW_READ  : rw value that requests a read  (1)
//   RW_WRITE : rw value that requests a write (0)
//   CNT_W    : width of the wait-cycle down-counter (holds latency-1, latency <= 15)
package pwp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int CNT_W = 4;

endpackage

// File: rtl/main_ram_if.sv
// Request/handshake bundle for main_ram. The shared data bus is a plain
// inout port on main_ram and is not part of this bundle.
//   addr : word address                 (master -> slave)
//   rw   : 1 = read, 0 = write          (master -> slave)
//   ce   : request valid / abort when 0 (master -> slave)
//   rdy  : one-cycle completion pulse   (slave -> master)
//   perr : parity error on a read, only when MAIN_RAM_PARITY_EN is defined
interface main_ram_if #(
    parameter int a_width = 8
);
    logic [a_width-1:0] addr;
    logic               rw;
    logic               ce;
    logic               rdy;
`ifdef MAIN_RAM_PARITY_EN
    logic               perr;

    modport master (output addr, output rw, output ce, input rdy, input perr);
    modport slave  (input addr, input rw, input ce, output rdy, output perr);
`else
    modport master (output addr, output rw, output ce, input rdy);
    modport slave  (input addr, input rw, input ce, output rdy);
`endif
endinterface

// File: rtl/ram_wait_cnt.sv
// Wait-cycle down-counter for main_ram.
//   clk      : clock
//   clr      : synchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over en)
//   en       : decrement by one; saturates at zero
//   load_val : value loaded on load
//   zero     : count is currently zero
module ram_wait_cnt #(
    parameter int cnt_width = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 en,
    input  logic [cnt_width-1:0] load_val,
    output logic                 zero
);

    localparam logic [cnt_width-1:0] CNT_ZERO = {cnt_width{1'b0}};
    localparam logic [cnt_width-1:0] CNT_ONE  = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [cnt_width-1:0] cnt_r;

    // Count register: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/main_ram.sv
// Single-port RAM with a fixed wait-state handshake on a shared data bus.
// A request is captured in IDLE, waits `latency` cycles in WAIT, and
// completes with a one-cycle rdy pulse in DONE. Reads drive the data bus
// only during DONE; writes never drive it. Dropping ce during WAIT aborts
// the access without touching memory.
//
// Ports:
//   clk  : clock, all state on posedge
//   clr  : synchronous active-low reset (does not clear memory)
//   data : shared data bus, sampled at capture on write, driven in DONE on read
//   bus  : main_ram_if.slave (addr, rw, ce, rdy[, perr])
//
// Optional feature: define MAIN_RAM_PARITY_EN to store an even-parity bit per
// word and report a mismatch on bus.perr during the DONE cycle of a read.
//
// Memory contents are not reset; simulators that zero-initialise variables
// start with an all-zero array.
module main_ram
    import pwp_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int latency = 2
) (
    input  logic               clk,
    input  logic               clr,
    inout  wire [d_width-1:0]  data,
    main_ram_if.slave          bus
);

    localparam int DEPTH = 2 ** a_width;
    // WAIT lasts `latency` cycles: counter walks latency-1 .. 0.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(latency - 1);

    state_e              state_r;
    state_e              state_s;

    logic [a_width-1:0]  addr_r;
    logic                rw_r;
    logic [d_width-1:0]  wdata_r;
    logic [d_width-1:0]  rdata_r;
    logic                rdy_r;
    logic                oe_r;

    logic                capture_s;
    logic                complete_s;
    logic                cnt_load_s;
    logic                cnt_en_s;
    logic                cnt_zero_s;

    logic [d_width-1:0]  mem_r [DEPTH];

`ifdef MAIN_RAM_PARITY_EN
    logic                par_r [DEPTH];
    logic                perr_r;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_par(input logic [d_width-1:0] word);
        return ^word;
    endfunction
`endif

    ram_wait_cnt #(
        .cnt_width (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .load_val (LOAD_VAL),
        .zero     (cnt_zero_s)
    );

    // Next-state and counter control for the access FSM.
    always_comb begin
        state_s    = state_r;
        capture_s  = 1'b0;
        complete_s = 1'b0;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.ce) begin
                    state_s    = WAIT;
                    capture_s  = 1'b1;
                    cnt_load_s = 1'b1;
                end else begin
                    state_s    = IDLE;
                end
            end
            WAIT: begin
                // Abort has priority over completion on the final wait cycle.
                if (!bus.ce) begin
                    state_s    = IDLE;
                end else if (cnt_zero_s) begin
                    state_s    = DONE;
                    complete_s = 1'b1;
                end else begin
                    state_s    = WAIT;
                    cnt_en_s   = 1'b1;
                end
            end
            DONE: begin
                // Always pass through IDLE so ce held high cannot re-capture here.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, request capture, read register and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= IDLE;
            addr_r  <= {a_width{1'b0}};
            rw_r    <= RW_READ;
            wdata_r <= {d_width{1'b0}};
            rdata_r <= {d_width{1'b0}};
            rdy_r   <= 1'b0;
            oe_r    <= 1'b0;
`ifdef MAIN_RAM_PARITY_EN
            perr_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            rdy_r   <= complete_s;
            oe_r    <= complete_s && (rw_r == RW_READ);
            if (capture_s) begin
                addr_r  <= bus.addr;
                rw_r    <= bus.rw;
                wdata_r <= data;
            end
            if (complete_s && (rw_r == RW_READ)) begin
                rdata_r <= mem_r[addr_r];
            end
`ifdef MAIN_RAM_PARITY_EN
            perr_r <= complete_s && (rw_r == RW_READ) &&
                      (even_par(mem_r[addr_r]) != par_r[addr_r]);
`endif
        end
    end

    // Storage write on WAIT->DONE of a write; reset blocks the write.
    always_ff @(posedge clk) begin
        if (clr && complete_s && (rw_r == RW_WRITE)) begin
            mem_r[addr_r] <= wdata_r;
`ifdef MAIN_RAM_PARITY_EN
            par_r[addr_r] <= even_par(wdata_r);
`endif
        end
    end

    assign bus.rdy = rdy_r;
    assign data    = oe_r ? rdata_r : {d_width{1'bz}};

`ifdef MAIN_RAM_PARITY_EN
    assign bus.perr = perr_r;
`endif

endmodule

// File: tb/tb_main_ram.sv
// Self-checking bench for main_ram (d_width=8, a_width=8, latency=2).
// The data bus is pulled high, so an undriven bus reads back as 8'hFF;
// stimulus never writes 8'hFF so a driven bus is always distinguishable.
module tb_main_ram;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       tb_oe;
    logic [7:0] tb_wd;
    tri1  [7:0] data;

    int checks   = 0;
    int failures = 0;

    main_ram_if #(.a_width(8)) bus ();

    assign data = tb_oe ? tb_wd : {8{1'bz}};

    main_ram #(
        .d_width (8),
        .a_width (8),
        .latency (LAT)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .data (data),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Tracks one outstanding request by its capture edge number: it completes
    // on edge capture+LAT if ce is still high, the next capture may happen no
    // earlier than two edges after completion (DONE cycle, then IDLE).
    logic [7:0] mem_m [256];
    logic       bad_m [256];
    int         edge_n  = 0;
    int         due     = 0;
    int         next_ok = 0;
    bit         pend    = 1'b0;
    bit         live    = 1'b0;
    logic       q_rw;
    logic [7:0] q_addr;
    logic [7:0] q_wd;
    logic       m_rdy   = 1'b0;
    logic       m_drv   = 1'b0;
    logic [7:0] m_val   = 8'h00;
    logic       m_perr  = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 8'h00;
            bad_m[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        m_rdy  = 1'b0;
        m_drv  = 1'b0;
        m_perr = 1'b0;
        if (!clr) begin
            pend    = 1'b0;
            next_ok = edge_n + 1;
        end else if (pend) begin
            if (!bus.ce) begin
                pend    = 1'b0;
                next_ok = edge_n + 1;
            end else if (edge_n == due) begin
                pend    = 1'b0;
                m_rdy   = 1'b1;
                next_ok = edge_n + 2;
                if (q_rw) begin
                    m_drv  = 1'b1;
                    m_val  = mem_m[q_addr];
                    m_perr = bad_m[q_addr];
                end else begin
                    mem_m[q_addr] = q_wd;
                    bad_m[q_addr] = 1'b0;
                end
            end
        end else if (bus.ce && (edge_n >= next_ok)) begin
            pend   = 1'b1;
            due    = edge_n + LAT;
            q_rw   = bus.rw;
            q_addr = bus.addr;
            q_wd   = data;
        end
        edge_n++;
        live = 1'b1;
    end

    // Cycle compare against the model, half a period after each edge.
    always @(negedge clk) begin
        if (live) begin
            chk("rdy", {31'd0, bus.rdy}, {31'd0, m_rdy});
            if (!tb_oe) begin
                chk("data", {24'd0, data}, {24'd0, (m_drv ? m_val : 8'hFF)});
            end
`ifdef MAIN_RAM_PARITY_EN
            chk("perr", {31'd0, bus.perr}, {31'd0, m_perr});
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic       got_rdy;
    logic [7:0] got_data;
    logic       got_perr = 1'b0;

    // Apply one cycle of inputs, then advance to just after the next edge.
    task automatic step(input logic c_clr, input logic c_ce, input logic c_rw,
                        input logic [7:0] c_addr, input logic [7:0] c_wd,
                        input logic c_drv);
        clr      = c_clr;
        bus.ce   = c_ce;
        bus.rw   = c_rw;
        bus.addr = c_addr;
        tb_wd    = c_wd;
        tb_oe    = c_drv;
        @(posedge clk);
        #2;
    endtask

    // Full access: data driven only in the capture cycle, addr scrambled
    // afterwards; outputs sampled in the cycle the access should complete.
    task automatic req(input logic r, input logic [7:0] a, input logic [7:0] wd,
                       output logic o_rdy, output logic [7:0] o_data);
        step(1'b1, 1'b1, r, a, wd, ~r);
        for (int i = 0; i < LAT; i++) begin
            step(1'b1, 1'b1, r, ~a, ~wd, 1'b0);
        end
        o_rdy  = bus.rdy;
        o_data = data;
`ifdef MAIN_RAM_PARITY_EN
        got_perr = bus.perr;
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    int         r1;
    int         r2;
    logic [7:0] d1;
    logic [7:0] d2;

    initial begin
        clr      = 1'b0;
        tb_oe    = 1'b0;
        tb_wd    = 8'h00;
        bus.ce   = 1'b0;
        bus.rw   = 1'b0;
        bus.addr = 8'h00;
        @(posedge clk);
        #2;
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("reset_rdy", {31'd0, bus.rdy}, 32'd0);
        chk("reset_data_z", {24'd0, data}, 32'h0000_00FF);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Write 0xA5 to 0x10, then read it back.
        req(1'b0, 8'h10, 8'hA5, got_rdy, got_data);
        chk("wr10_rdy", {31'd0, got_rdy}, 32'd1);
        chk("wr10_data_z", {24'd0, got_data}, 32'h0000_00FF);
        req(1'b1, 8'h10, 8'h00, got_rdy, got_data);
        chk("rd10_rdy", {31'd0, got_rdy}, 32'd1);
        chk("rd10_data", {24'd0, got_data}, 32'h0000_00A5);
        req(1'b0, 8'h11, 8'h5A, got_rdy, got_data);
        chk("wr11_rdy", {31'd0, got_rdy}, 32'd1);

        // Write 0x3C to 0x20 aborted after one wait cycle.
        step(1'b1, 1'b1, 1'b0, 8'h20, 8'h3C, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h20, 8'h3C, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h20, 8'h3C, 1'b0);
        chk("abort_rdy", {31'd0, bus.rdy}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("abort_rdy2", {31'd0, bus.rdy}, 32'd0);
        req(1'b1, 8'h20, 8'h00, got_rdy, got_data);
        chk("rd20_rdy", {31'd0, got_rdy}, 32'd1);
        chk("rd20_data", {24'd0, got_data}, 32'h0000_0000);

        // Reset in the middle of a read of 0x10.
        step(1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0);
        chk("midrst_rdy", {31'd0, bus.rdy}, 32'd0);
        chk("midrst_idle", {30'd0, dut.state_r}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("midrst_rdy2", {31'd0, bus.rdy}, 32'd0);
        req(1'b1, 8'h10, 8'h00, got_rdy, got_data);
        chk("rd10_after_rst", {24'd0, got_data}, 32'h0000_00A5);

        // Back-to-back reads with ce held high: 0x10 then 0x11.
        r1 = -1;
        r2 = -1;
        d1 = 8'h00;
        d2 = 8'h00;
        for (int i = 0; i < 2 * LAT + 4; i++) begin
            step(1'b1, 1'b1, 1'b1, (i < LAT + 2) ? 8'h10 : 8'h11, 8'h00, 1'b0);
            if (bus.rdy) begin
                if (r1 < 0) begin
                    r1 = i;
                    d1 = data;
                end else begin
                    r2 = i;
                    d2 = data;
                end
            end
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("b2b_first_rdy", r1, 32'd2);
        chk("b2b_second_rdy", r2, 32'd6);
        chk("b2b_first_data", {24'd0, d1}, 32'h0000_00A5);
        chk("b2b_second_data", {24'd0, d2}, 32'h0000_005A);

        // Address extremes.
        req(1'b0, 8'hFF, 8'h81, got_rdy, got_data);
        req(1'b0, 8'h00, 8'h7E, got_rdy, got_data);
        req(1'b1, 8'hFF, 8'h00, got_rdy, got_data);
        chk("rdFF_data", {24'd0, got_data}, 32'h0000_0081);
        req(1'b1, 8'h00, 8'h00, got_rdy, got_data);
        chk("rd00_data", {24'd0, got_data}, 32'h0000_007E);

`ifdef MAIN_RAM_PARITY_EN
        // Corrupt bit 0 of the stored word at 0x10 behind the parity bit.
        dut.mem_r[8'h10] <= dut.mem_r[8'h10] ^ 8'h01;
        mem_m[8'h10] = mem_m[8'h10] ^ 8'h01;
        bad_m[8'h10] = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        req(1'b1, 8'h10, 8'h00, got_rdy, got_data);
        chk("par_bad_rdy", {31'd0, got_rdy}, 32'd1);
        chk("par_bad_perr", {31'd0, got_perr}, 32'd1);
        chk("par_bad_data", {24'd0, got_data}, 32'h0000_00A4);
        req(1'b1, 8'h11, 8'h00, got_rdy, got_data);
        chk("par_ok_perr", {31'd0, got_perr}, 32'd0);
`endif

        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
